// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: framing, E0/F0 prefixes, held-key map.
// Optional: PS2_TYPEMATIC_FILTER_EN drops KeyPress on typematic repeat.
module ps2_key_decoder #(
  parameter int NUM_KEYS = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES =
    {8'h20, 8'h1F, 8'h1E, 8'h11},
  parameter logic [NUM_KEYS-1:0] KEY_EXT = '0,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                PS2Clock,
  input  logic                PS2Data,
  output logic [NUM_KEYS-1:0] KeyDown,
  output logic [NUM_KEYS-1:0] KeyPress,
  output logic                CodeValid,
  output logic [7:0]          Code,
  output logic                CodeBreak,
  output logic                CodeExtended,
  output logic                FrameError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  state_t state, nstate;

  logic [SYNC_STAGES-1:0] ck_sync;
  logic [SYNC_STAGES-1:0] dt_sync;
  logic                   ck_prev;
  logic                   ps2_ck;
  logic                   ps2_dt;
  logic                   fall;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par_q;
  logic [TW-1:0]          tcnt;
  logic                   ext;
  logic                   brk;
  logic                   tmo;
  logic                   frame_ok;
  logic                   frame_bad;
  logic                   is_e0;
  logic                   is_f0;

  assign ps2_ck = ck_sync[SYNC_STAGES-1];
  assign ps2_dt = dt_sync[SYNC_STAGES-1];
  assign fall   = ck_prev & ~ps2_ck;
  assign is_e0  = (shreg == 8'hE0);
  assign is_f0  = (shreg == 8'hF0);

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= nstate;
  end

  // Next-state: frame walk, timeout aborts back to IDLE
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (fall && !ps2_dt)        nstate = DATA;
      DATA:   if (fall && bitcnt == 3'd7) nstate = PARITY;
      PARITY: if (fall)                   nstate = STOP;
      STOP:   if (fall)                   nstate = IDLE;
      default:                            nstate = IDLE;
    endcase
    if (tmo) nstate = IDLE;
  end

  // Frame status: stop-bit check, odd parity, inter-edge timeout
  always_comb begin
    tmo       = (state != IDLE) && !fall && (tcnt == TMAX);
    frame_ok  = 1'b0;
    frame_bad = tmo;
    if (state == STOP && fall) begin
      frame_ok  = ps2_dt & (^{par_q, shreg});
      frame_bad = ~frame_ok;
    end
  end

  // Synchronisers, shift register and timeout counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ck_sync <= '1;
      dt_sync <= '1;
      ck_prev <= 1'b1;
      bitcnt  <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      ck_sync <= {ck_sync[SYNC_STAGES-2:0], PS2Clock};
      dt_sync <= {dt_sync[SYNC_STAGES-2:0], PS2Data};
      ck_prev <= ps2_ck;
      if (fall || state == IDLE) tcnt <= '0;
      else                       tcnt <= tcnt + 1'b1;
      if (state == IDLE) bitcnt <= '0;
      if (fall && state == DATA) begin
        shreg  <= {ps2_dt, shreg[7:1]};
        bitcnt <= bitcnt + 3'd1;
      end
      if (fall && state == PARITY) par_q <= ps2_dt;
    end
  end

  // Byte decode: prefixes, code strobe, key map
  always_ff @(posedge Clock) begin
    if (Reset) begin
      KeyDown      <= '0;
      KeyPress     <= '0;
      CodeValid    <= 1'b0;
      Code         <= '0;
      CodeBreak    <= 1'b0;
      CodeExtended <= 1'b0;
      FrameError   <= 1'b0;
      ext          <= 1'b0;
      brk          <= 1'b0;
    end else begin
      KeyPress   <= '0;
      CodeValid  <= 1'b0;
      FrameError <= 1'b0;
      unique case (1'b1)
        frame_bad: begin
          FrameError <= 1'b1;
          ext        <= 1'b0;
          brk        <= 1'b0;
        end
        frame_ok && is_e0: ext <= 1'b1;
        frame_ok && is_f0: brk <= 1'b1;
        frame_ok && !is_e0 && !is_f0: begin
          CodeValid    <= 1'b1;
          Code         <= shreg;
          CodeBreak    <= brk;
          CodeExtended <= ext;
          ext          <= 1'b0;
          brk          <= 1'b0;
          for (int i = 0; i < NUM_KEYS; i++) begin
            if (shreg == KEY_CODES[8*i +: 8] &&
                ext == KEY_EXT[i]) begin
              if (brk) begin
                KeyDown[i] <= 1'b0;
              end else begin
                KeyDown[i] <= 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                if (!KeyDown[i]) KeyPress[i] <= 1'b1;
`else
                KeyPress[i] <= 1'b1;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
